// File: rtl/deserializer.sv
// Serial-to-byte deserializer with comma-based byte alignment.
// Two commas 8 bits apart establish lock; a comma off the byte boundary drops back to ALIGN.
module deserializer #(
    parameter logic [7:0] COMMA = 8'hBC
) (
    input  logic       clk,
    input  logic       reset_L,
    input  logic       enb,
    input  logic       serial_in,
    output logic [7:0] data,
    output logic       valid,
    output logic       DK,
    output logic       sync,
    output logic       err
);

    typedef enum logic [1:0] {StSearch, StAlign, StLocked} state_t;

    state_t     state;
    logic [7:0] sr;
    logic [2:0] cnt;
    logic [7:0] nsr;
    logic       is_comma;
    logic       last_bit;

    assign nsr      = {sr[6:0], serial_in};
    assign is_comma = (nsr == COMMA);
    assign last_bit = (cnt == 3'd7);

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state <= StSearch;
            sr    <= 8'h00;
            cnt   <= 3'd0;
            data  <= 8'h00;
            DK    <= 1'b0;
            valid <= 1'b0;
            sync  <= 1'b0;
            err   <= 1'b0;
        end else begin
            // Pulses default low; everything else holds unless a bit is sampled.
            valid <= 1'b0;
            err   <= 1'b0;
            if (enb) begin
                sr <= nsr;
                case (state)
                    StSearch: begin
                        if (is_comma) begin
                            state <= StAlign;
                            cnt   <= 3'd0;
                        end
                    end
                    StAlign: begin
                        if (last_bit) begin
                            cnt <= 3'd0;
                            if (is_comma) begin
                                state <= StLocked;
                                sync  <= 1'b1;
                            end else begin
                                state <= StSearch;
                                err   <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                    StLocked: begin
                        if (last_bit) begin
                            cnt   <= 3'd0;
                            data  <= nsr;
                            DK    <= is_comma;
                            valid <= 1'b1;
                        end else if (is_comma) begin
                            // Comma off the byte boundary: realign on it.
                            state <= StAlign;
                            sync  <= 1'b0;
                            cnt   <= 3'd0;
                            err   <= 1'b1;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                    default: begin
                        state <= StSearch;
                        sync  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for deserializer: MSB-first byte streams with hand-computed expectations.
module tb_deserializer;

    logic       clk = 1'b0;
    logic       reset_L = 1'b0;
    logic       enb = 1'b0;
    logic       serial_in = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       DK;
    logic       sync;
    logic       err;

    int n_checks = 0;
    int n_pass = 0;
    int n_valid = 0;
    int n_err = 0;
    int n_dbl = 0;
    int n_bad = 0;
    int v0;
    int e0;
    logic prev_valid = 1'b0;
    logic prev_err = 1'b0;
    logic last_enb = 1'b0;

    deserializer #(.COMMA(8'hBC)) dut (
        .clk      (clk),
        .reset_L  (reset_L),
        .enb      (enb),
        .serial_in(serial_in),
        .data     (data),
        .valid    (valid),
        .DK       (DK),
        .sync     (sync),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Sees the pulse values registered on the previous edge; last_enb is that edge's enb.
    always @(posedge clk) begin
        if (valid) begin
            n_valid++;
            if (prev_valid) n_dbl++;
            if (!last_enb) n_bad++;
        end
        if (err) begin
            n_err++;
            if (prev_err) n_dbl++;
        end
        prev_valid = valid;
        prev_err   = err;
        last_enb   = enb;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic send_bit(input logic b, input bit gap);
        if (gap) begin
            @(negedge clk);
            enb = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        enb       = 1'b1;
        serial_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] v, input bit gap);
        for (int i = 7; i >= 0; i--) send_bit(v[i], gap);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            enb = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_data", data, 8'h00);
        check("rst_dk", DK, 1'b0);
        check("rst_valid", valid, 1'b0);
        check("rst_sync", sync, 1'b0);
        check("rst_err", err, 1'b0);
        @(negedge clk);
        reset_L = 1'b1;

        // Acquire lock on BC,BC then receive 88
        send_byte(8'hBC, 1'b0);
        check("sync_after_8", sync, 1'b0);
        send_byte(8'hBC, 1'b0);
        check("sync_after_16", sync, 1'b1);
        send_byte(8'h88, 1'b0);
        check("t1_valid", valid, 1'b1);
        check("t1_data", data, 8'h88);
        check("t1_dk", DK, 1'b0);
        idle(2);
        check("t1_valid_count", n_valid, 1);
        check("t1_valid_low", valid, 1'b0);
        check("t1_data_hold", data, 8'h88);

        // Boundary comma delivered as control, lock kept
        v0 = n_valid;
        send_byte(8'hBC, 1'b0);
        check("t2_valid_bc", valid, 1'b1);
        check("t2_data_bc", data, 8'hBC);
        check("t2_dk_bc", DK, 1'b1);
        check("t2_sync_bc", sync, 1'b1);
        send_byte(8'h55, 1'b0);
        check("t2_valid_55", valid, 1'b1);
        check("t2_data_55", data, 8'h55);
        check("t2_dk_55", DK, 1'b0);
        check("t2_sync_55", sync, 1'b1);
        idle(2);
        check("t2_valid_count", n_valid - v0, 2);

        // enb toggling during a byte
        v0 = n_valid;
        send_byte(8'h3C, 1'b1);
        check("t3_valid", valid, 1'b1);
        check("t3_data", data, 8'h3C);
        check("t3_dk", DK, 1'b0);
        idle(2);
        check("t3_valid_count", n_valid - v0, 1);
        check("t3_valid_while_idle", n_bad, 0);

        // 3 slip bits: 000 + 10111 is delivered as 0x17, then the comma lands off-boundary
        v0 = n_valid;
        e0 = n_err;
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_byte(8'hBC, 1'b0);
        check("t4_err", err, 1'b1);
        check("t4_sync_lost", sync, 1'b0);
        check("t4_valid_on_err", valid, 1'b0);
        check("t4_slip_data", data, 8'h17);
        send_byte(8'hBC, 1'b0);
        check("t4_relock", sync, 1'b1);
        send_byte(8'hA5, 1'b0);
        check("t4_valid", valid, 1'b1);
        check("t4_data", data, 8'hA5);
        idle(2);
        check("t4_valid_count", n_valid - v0, 2);
        check("t4_err_count", n_err - e0, 1);

        // Reset mid-byte
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        #2;
        reset_L = 1'b0;
        #1;
        check("t5_async_clear", {data, DK, valid, sync, err}, 12'h000);
        idle(2);
        @(negedge clk);
        reset_L = 1'b1;
        v0 = n_valid;
        send_byte(8'h66, 1'b0);
        send_byte(8'h33, 1'b0);
        idle(2);
        check("t5_no_valid", n_valid - v0, 0);
        check("t5_sync", sync, 1'b0);

        // Single comma followed by data fails alignment
        e0 = n_err;
        send_byte(8'hBC, 1'b0);
        send_byte(8'h88, 1'b0);
        check("t6_err", err, 1'b1);
        check("t6_sync", sync, 1'b0);
        check("t6_valid", valid, 1'b0);
        idle(1);
        check("t6_err_pulse", err, 1'b0);
        idle(1);
        check("t6_err_count", n_err - e0, 1);
        check("t6_no_valid", n_valid - v0, 0);

        // Relock after the failures
        send_byte(8'hBC, 1'b0);
        send_byte(8'hBC, 1'b0);
        send_byte(8'h5A, 1'b0);
        check("t7_valid", valid, 1'b1);
        check("t7_data", data, 8'h5A);
        check("t7_sync", sync, 1'b1);
        idle(2);
        check("pulse_width", n_dbl, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/deserializer.md
DESERIALIZER -- requirements
Module: deserializer

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 reset_L  input  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
REQ-003 enb  input  1  bit enable; a serial bit is sampled only on edges where enb=1.
REQ-004 serial_in  input  1  serial data from the serializer, MSB of each byte first.
REQ-005 data  output  8  last received byte, registered.
REQ-006 valid  output  1  one-cycle pulse; data/DK are new on this cycle.
REQ-007 DK  output  1  1 = received byte is the comma control character 8'hBC, 0 = data byte; qualified by valid.
REQ-008 sync  output  1  1 while in LOCKED state.
REQ-009 err  output  1  one-cycle pulse on alignment failure or misaligned comma.

Function
REQ-010 Parameter COMMA, default 8'hBC, the alignment/control character.
REQ-011 Shift register sr[7:0]: on enb=1, sr <= {sr[6:0], serial_in}; nsr denotes {sr[6:0], serial_in} (next value).
REQ-012 Bit counter cnt[2:0] counts enabled bits within a byte; wraps 7 -> 0.
REQ-013 States SEARCH, ALIGN, LOCKED; reset state SEARCH.
REQ-014 SEARCH: on enb=1 and nsr==COMMA -> ALIGN, cnt <= 0; otherwise stay; no valid.
REQ-015 ALIGN: cnt increments per enabled bit; on enb=1 and cnt==7: nsr==COMMA -> LOCKED; else -> SEARCH and err pulses one cycle.
REQ-016 ALIGN produces no valid; the two alignment commas are not delivered.
REQ-017 LOCKED: on enb=1 and cnt==7 -> data <= nsr, DK <= (nsr==COMMA), valid <= 1 next cycle; cnt wraps to 0.
REQ-018 Latency: valid high the cycle immediately after the edge that samples the 8th bit of a byte.
REQ-019 LOCKED, misaligned comma (enb=1, cnt!=7, nsr==COMMA): -> ALIGN, cnt <= 0, err pulses, no valid that cycle.
REQ-020 Boundary comma (cnt==7) in LOCKED is delivered as data=8'hBC, DK=1; lock retained.
REQ-021 enb=0: sr, cnt, state, data, DK hold; valid and err driven 0.
REQ-022 valid and err are never high for more than one consecutive cycle.
REQ-023 sync is registered and equals (state==LOCKED).
REQ-024 data and DK hold their last values between valid pulses.

Reset
REQ-025 reset_L=0 asynchronously forces: state SEARCH, sr 8'h00, cnt 0, data 8'h00, DK 0, valid 0, sync 0, err 0.
REQ-026 Reset asserted mid-byte discards the partial byte; no valid is produced for it after release.
REQ-027 After reset_L rises, first sample taken on the first rising edge with enb=1.

Verification
REQ-028 Reset then enb=1, stream BC,BC,88 MSB-first -> sync=1 after 16th bit; valid pulse after 24th bit with data=8'h88, DK=0.
REQ-029 Locked, stream BC,55 -> two valid pulses: data=8'hBC DK=1, then data=8'h55 DK=0; sync stays 1.
REQ-030 Stream BC then 8'h88 (no second comma) -> err one-cycle pulse, state SEARCH, no valid, sync=0.
REQ-031 Locked, insert 3 extra bits then BC,BC,A5 -> err on misaligned comma, sync=0, then relock, valid with data=8'hA5.
REQ-032 Locked, enb toggling 1/0 every cycle during byte 8'h3C -> data=8'h3C after 8 enabled bits; valid only once, never while enb=0.
REQ-033 reset_L pulsed low after 4 bits of a locked byte -> all outputs 0 immediately, no valid after release until BC,BC relock.
